// File: rtl/pwm_breathe_pkg.sv
// Shared mode/direction encodings and the output-enable decode for the
// multi-channel breathing PWM generator.
package pwm_breathe_pkg;

    localparam logic [1:0] MODE_OFF     = 2'b00;
    localparam logic [1:0] MODE_STATIC  = 2'b01;
    localparam logic [1:0] MODE_BREATHE = 2'b10;
    localparam logic [1:0] MODE_BLINK   = 2'b11;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // A channel drives its compare result only when its mode (and blink phase) allow it.
    function automatic logic chan_on(input logic [1:0] mode, input logic phase);
        logic on_v;
        case (mode)
            MODE_STATIC, MODE_BREATHE: on_v = 1'b1;
            MODE_BLINK:                on_v = phase;
            default:                   on_v = 1'b0;
        endcase
        return on_v;
    endfunction

endpackage

// File: rtl/pwm_breathe_chan.sv
// One PWM channel: holds mode, level, ramp direction and blink phase, and
// produces a registered compare output against the shared period counter.
module pwm_breathe_chan
    import pwm_breathe_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [PWM_BITS-1:0] cnt,
    input  logic                upd,
    input  logic                we,
    input  logic [1:0]          wr_mode,
    input  logic [PWM_BITS-1:0] wr_level,
    output logic                pwm
);

    localparam logic [PWM_BITS-1:0] LVL_MAX  = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] LVL_ZERO = {PWM_BITS{1'b0}};
    localparam logic [PWM_BITS-1:0] LVL_ONE  = PWM_BITS'(1);

    logic [1:0]          mode_r,  mode_nxt_s;
    logic [PWM_BITS-1:0] level_r, level_nxt_s;
    logic                dir_r,   dir_nxt_s;
    logic                phase_r, phase_nxt_s;
    logic                pwm_r;

    // Next channel state: a write beats a same-cycle ramp/blink step.
    always_comb begin
        mode_nxt_s  = mode_r;
        level_nxt_s = level_r;
        dir_nxt_s   = dir_r;
        phase_nxt_s = phase_r;
        if (we) begin
            mode_nxt_s  = wr_mode;
            level_nxt_s = wr_level;
            dir_nxt_s   = DIR_UP;
            phase_nxt_s = 1'b1;
        end else if (upd) begin
            case (mode_r)
                MODE_BREATHE: begin
                    // Endpoints turn around immediately so max and 0 dwell one step only.
                    if (dir_r == DIR_UP) begin
                        if (level_r == LVL_MAX) begin
                            dir_nxt_s   = DIR_DOWN;
                            level_nxt_s = LVL_MAX - LVL_ONE;
                        end else begin
                            level_nxt_s = level_r + LVL_ONE;
                        end
                    end else begin
                        if (level_r == LVL_ZERO) begin
                            dir_nxt_s   = DIR_UP;
                            level_nxt_s = LVL_ONE;
                        end else begin
                            level_nxt_s = level_r - LVL_ONE;
                        end
                    end
                end
                MODE_BLINK: phase_nxt_s = ~phase_r;
                default:    phase_nxt_s = phase_r;
            endcase
        end else begin
            phase_nxt_s = phase_r;
        end
    end

    // Channel state and registered compare output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_r  <= MODE_OFF;
            level_r <= LVL_ZERO;
            dir_r   <= DIR_UP;
            phase_r <= 1'b0;
            pwm_r   <= 1'b0;
        end else begin
            mode_r  <= mode_nxt_s;
            level_r <= level_nxt_s;
            dir_r   <= dir_nxt_s;
            phase_r <= phase_nxt_s;
            pwm_r   <= en & chan_on(mode_r, phase_r) & (cnt < level_r);
        end
    end

    assign pwm = pwm_r;

endmodule

// File: rtl/pwm_breathe_multi.sv
// Multi-channel breathing/dimming LED PWM: shared period counter and
// prescaler, config decode, and one pwm_breathe_chan per output.
module pwm_breathe_multi
    import pwm_breathe_pkg::*;
#(
    parameter int NCH        = 4,
    parameter int PWM_BITS   = 8,
    parameter int PRESC_BITS = 8,
    localparam int CHW       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [PRESC_BITS-1:0] presc,
    input  logic                  cfg_we,
    input  logic [CHW-1:0]        cfg_ch,
    input  logic [1:0]            cfg_mode,
    input  logic [PWM_BITS-1:0]   cfg_level,
    output logic [NCH-1:0]        pwm_out,
    output logic                  period_tick
);

    localparam logic [PWM_BITS-1:0] CNT_MAX = {PWM_BITS{1'b1}};

    logic [PWM_BITS-1:0]   cnt_r;
    logic [PRESC_BITS-1:0] pcnt_r;
    logic                  upd_s;

    assign period_tick = en & (cnt_r == CNT_MAX);
    // Level steps fire on the last clock of a period so they land exactly at the wrap.
    assign upd_s = period_tick & (pcnt_r >= presc);

    // Period counter and prescaler; both freeze while en is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r  <= {PWM_BITS{1'b0}};
            pcnt_r <= {PRESC_BITS{1'b0}};
        end else begin
            if (en) begin
                cnt_r <= cnt_r + PWM_BITS'(1);
            end else begin
                cnt_r <= cnt_r;
            end
            if (period_tick) begin
                pcnt_r <= upd_s ? {PRESC_BITS{1'b0}} : pcnt_r + PRESC_BITS'(1);
            end else begin
                pcnt_r <= pcnt_r;
            end
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        logic we_s;
        // Out-of-range channel numbers match no instance, so such writes vanish.
        assign we_s = cfg_we & (cfg_ch == CHW'(i));

        pwm_breathe_chan #(
            .PWM_BITS (PWM_BITS)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .en       (en),
            .cnt      (cnt_r),
            .upd      (upd_s),
            .we       (we_s),
            .wr_mode  (cfg_mode),
            .wr_level (cfg_level),
            .pwm      (pwm_out[i])
        );
    end

endmodule

// File: tb/tb_pwm_breathe_multi.sv
// Self-checking bench: directed scenarios plus random traffic, compared each
// clock against a triangle-position reference model of every channel.
module tb_pwm_breathe_multi;

    localparam int NCH = 4;
    localparam int PB  = 4;
    localparam int MAXL = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [1:0] presc = 2'd0;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_ch = 2'd0;
    logic [1:0] cfg_mode = 2'd0;
    logic [3:0] cfg_level = 4'd0;
    logic [3:0] pwm_out;
    logic       period_tick;
    logic [2:0] pwm_out3;
    logic       period_tick3;

    int checks = 0;
    int errors = 0;

    // reference model state
    int m_cnt, m_pcnt;
    int m_mode[NCH];
    int m_pos[NCH];     // position on the 0..2*MAXL-1 triangle
    int m_phase[NCH];

    pwm_breathe_multi #(.NCH(4), .PWM_BITS(PB), .PRESC_BITS(2)) u_dut (
        .clk(clk), .rst(rst), .en(en), .presc(presc), .cfg_we(cfg_we),
        .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_level(cfg_level),
        .pwm_out(pwm_out), .period_tick(period_tick)
    );

    pwm_breathe_multi #(.NCH(3), .PWM_BITS(PB), .PRESC_BITS(2)) u_dut3 (
        .clk(clk), .rst(rst), .en(en), .presc(presc), .cfg_we(cfg_we),
        .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_level(cfg_level),
        .pwm_out(pwm_out3), .period_tick(period_tick3)
    );

    always #5 clk = ~clk;

    function automatic int lvl(input int pos);
        return (pos <= MAXL) ? pos : (2 * MAXL - pos);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0;
        m_pcnt = 0;
        for (int c = 0; c < NCH; c++) begin
            m_mode[c] = 0; m_pos[c] = 0; m_phase[c] = 0;
        end
    endtask

    // One clock: called just after a falling edge with inputs already driven.
    task automatic tick();
        logic [3:0] exp_pwm;
        logic       exp_tick, upd, on;
        #1;
        exp_tick = en && (m_cnt == MAXL);
        chk("period_tick", {31'd0, period_tick}, {31'd0, exp_tick});
        chk("period_tick3", {31'd0, period_tick3}, {31'd0, exp_tick});
        for (int c = 0; c < NCH; c++) begin
            on = (m_mode[c] == 1) || (m_mode[c] == 2) || (m_mode[c] == 3 && m_phase[c] == 1);
            exp_pwm[c] = en && on && (m_cnt < lvl(m_pos[c]));
        end
        upd = exp_tick && (m_pcnt >= int'(presc));
        if (exp_tick) m_pcnt = upd ? 0 : m_pcnt + 1;
        if (en) m_cnt = (m_cnt + 1) % (MAXL + 1);
        for (int c = 0; c < NCH; c++) begin
            if (cfg_we && int'(cfg_ch) == c) begin
                m_mode[c] = int'(cfg_mode); m_pos[c] = int'(cfg_level); m_phase[c] = 1;
            end else if (upd && m_mode[c] == 2) begin
                m_pos[c] = (m_pos[c] + 1) % (2 * MAXL);
            end else if (upd && m_mode[c] == 3) begin
                m_phase[c] = 1 - m_phase[c];
            end
        end
        @(posedge clk);
        @(negedge clk);
        chk("pwm_out", {28'd0, pwm_out}, {28'd0, exp_pwm});
        chk("pwm_out3", {29'd0, pwm_out3}, {29'd0, exp_pwm[2:0]});
    endtask

    task automatic wr(input int ch, input int mode, input int level);
        cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_mode = 2'(mode); cfg_level = 4'(level);
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic align(input int target);
        int guard = 0;
        while (m_cnt != target && guard < 40) begin
            tick();
            guard++;
        end
        chk("align_bound", {31'd0, (guard >= 40)}, 32'd0);
    endtask

    initial begin
        int hi;
        model_reset();
        #1;
        chk("reset_pwm", {28'd0, pwm_out}, 32'd0);
        chk("reset_tick", {31'd0, period_tick}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        en = 1'b1;

        // 1: async reset mid-period with an output high
        wr(0, 1, 15);
        for (int k = 0; k < 5; k++) tick();
        chk("pre_reset_high", {31'd0, pwm_out[0]}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_pwm", {28'd0, pwm_out}, 32'd0);
        chk("async_reset_tick", {31'd0, period_tick}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int k = 0; k < 15; k++) tick();
        #1;
        chk("first_tick_after_reset", {31'd0, period_tick}, 32'd1);

        // 2: static level 4 -> 4 highs per period
        align(0);
        wr(0, 1, 4);
        align(0);
        hi = 0;
        for (int k = 0; k < 16; k++) begin
            tick();
            hi += int'(pwm_out[0]);
        end
        chk("static_duty", 32'(hi), 32'd4);

        // 3: breathing channel from level 0, step every 2 periods
        presc = 2'd1;
        wr(1, 2, 0);
        for (int k = 0; k < 64 * 16; k++) tick();

        // 4: blink written on the last clock (collides with upd): high period then low period
        presc = 2'd0;
        align(MAXL);
        wr(2, 3, 15);
        hi = 0;
        for (int k = 0; k < 16; k++) begin
            tick();
            hi += int'(pwm_out[2]);
        end
        chk("blink_on_period", 32'(hi), 32'd15);
        hi = 0;
        for (int k = 0; k < 16; k++) begin
            tick();
            hi += int'(pwm_out[2]);
        end
        chk("blink_off_period", 32'(hi), 32'd0);

        // 5: write a breathing channel on the upd cycle; out-of-range write on 3-channel part
        align(MAXL);
        wr(1, 2, 7);
        for (int k = 0; k < 40; k++) tick();
        wr(3, 1, 9);
        for (int k = 0; k < 40; k++) tick();

        // 6: drop enable mid-period for 10 clocks
        align(6);
        en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("en_low_pwm", {28'd0, pwm_out}, 32'd0);
        end
        en = 1'b1;
        for (int k = 0; k < 48; k++) tick();

        // random traffic
        for (int k = 0; k < 1500; k++) begin
            en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 49) == 0) presc = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) begin
                wr($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 15));
            end else begin
                tick();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
